// File: rtl/pl_frame_scheduler.sv
// pl_frame_scheduler
//   Sequencing controller for the DVB-S2 PL header generator and payload
//   symbol path. For each frame it accepts a descriptor, runs the header
//   generator, then paces payload reads slot by slot (90 symbols per slot).
//   When transmission is enabled and no descriptor is waiting, it emits a
//   dummy PLFRAME so the symbol stream never starves.
//
//   Build option: PILOT_INSERT_EN
//     defined   - 36-cycle pilot blocks are inserted after every 16th slot
//                 of pilot-flagged, non-dummy frames.
//     undefined - no pilot state; hdr_pls[6] is forced to 0.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   tx_en          permits starting new frames (a running frame completes)
//   frm_valid/frm_ready/frm_pls/frm_slots   descriptor handshake
//   hdr_en, hdr_pls, hdr_ready              header generator interface
//   sym_sel        00 idle, 01 header, 10 payload, 11 pilot
//   pay_rd         one payload symbol consumed this cycle
//   slot_cnt       index of the current payload slot
//   frame_start    pulse in the first header cycle
//   frame_done     pulse in the single DONE cycle
//   dummy_active   current frame is a dummy frame
//   hdr_err        sticky header-timeout flag, cleared only by rst
//   state_dbg      current FSM state (IDLE=0, HDR=1, PAY=2, DONE=3, PILOT=4)
//
// Handshake: a descriptor transfers on a rising edge where
// frm_valid & frm_ready are both 1. frm_ready is high only in IDLE with
// tx_en set and never depends on frm_valid; the producer must hold
// frm_pls/frm_slots stable while frm_valid is high and not yet accepted.
`timescale 1ns/1ps
module pl_frame_scheduler #(
    parameter int MAX_SLOTS   = 360,
    parameter int HDR_TIMEOUT = 255,
    parameter int DUMMY_SLOTS = 36
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       frm_valid,
    output logic       frm_ready,
    input  logic [6:0] frm_pls,
    input  logic [8:0] frm_slots,
    output logic       hdr_en,
    output logic [6:0] hdr_pls,
    input  logic       hdr_ready,
    output logic [1:0] sym_sel,
    output logic       pay_rd,
    output logic [8:0] slot_cnt,
    output logic       frame_start,
    output logic       frame_done,
    output logic       dummy_active,
    output logic       hdr_err,
    output logic [2:0] state_dbg
);

    localparam int              HCW        = $clog2(HDR_TIMEOUT + 1);
    localparam logic [8:0]      MAX_S      = 9'(MAX_SLOTS);
    localparam logic [8:0]      DUMMY_S    = 9'(DUMMY_SLOTS);
    localparam logic [HCW-1:0]  HDR_LAST   = HCW'(HDR_TIMEOUT - 1);
    localparam logic [HCW-1:0]  HDR_QUAL   = HCW'(2);
    localparam logic [6:0]      SYM_LAST   = 7'd89;
    localparam logic [6:0]      PILOT_LAST = 7'd35;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PAY   = 3'd2,
        S_DONE  = 3'd3
`ifdef PILOT_INSERT_EN
        ,
        S_PILOT = 3'd4
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     pls_q;
    logic [8:0]     slots_q;
    logic [HCW-1:0] hdr_cnt_q;
    logic [6:0]     sym_cnt_q;   // payload symbol index, reused as pilot cycle index
    logic [8:0]     slot_q;
    logic           dummy_q;
    logic           err_q;

    logic last_sym;
    logic last_slot;
`ifdef PILOT_INSERT_EN
    logic pilot_due;
`endif

    function automatic logic [8:0] clamp_slots(input logic [8:0] s);
        if (s == 9'd0)
            return 9'd1;
        else if (s > MAX_S)
            return MAX_S;
        else
            return s;
    endfunction

    assign last_sym  = (sym_cnt_q == SYM_LAST);
    assign last_slot = (slot_q == slots_q - 9'd1);
`ifdef PILOT_INSERT_EN
    // slot_cnt + 1 is a multiple of 16 exactly when the low nibble is all ones.
    assign pilot_due = (slot_q[3:0] == 4'hF) && pls_q[6] && !dummy_q;
    assign hdr_pls   = pls_q;
`else
    assign hdr_pls   = pls_q & 7'h3F;
`endif

    assign slot_cnt     = slot_q;
    assign dummy_active = dummy_q;
    assign hdr_err      = err_q;
    assign state_dbg    = state_q;

    always_comb begin
        state_d     = state_q;
        frm_ready   = 1'b0;
        hdr_en      = 1'b0;
        sym_sel     = 2'b00;
        pay_rd      = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                frm_ready = tx_en;
                if (tx_en)
                    state_d = S_HDR;
            end
            S_HDR: begin
                hdr_en      = 1'b1;
                sym_sel     = 2'b01;
                frame_start = (hdr_cnt_q == '0);
                // The first two cycles may still see the previous frame's ready.
                if (hdr_ready && hdr_cnt_q >= HDR_QUAL)
                    state_d = S_PAY;
                else if (hdr_cnt_q == HDR_LAST)
                    state_d = S_DONE;
            end
            S_PAY: begin
                pay_rd  = 1'b1;
                sym_sel = 2'b10;
                if (last_sym) begin
                    if (last_slot)
                        state_d = S_DONE;
`ifdef PILOT_INSERT_EN
                    else if (pilot_due)
                        state_d = S_PILOT;
`endif
                end
            end
`ifdef PILOT_INSERT_EN
            S_PILOT: begin
                sym_sel = 2'b11;
                if (sym_cnt_q == PILOT_LAST)
                    state_d = S_PAY;
            end
`endif
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pls_q     <= '0;
            slots_q   <= '0;
            hdr_cnt_q <= '0;
            sym_cnt_q <= '0;
            slot_q    <= '0;
            dummy_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    hdr_cnt_q <= '0;
                    sym_cnt_q <= '0;
                    if (tx_en) begin
                        if (frm_valid) begin
                            pls_q   <= frm_pls;
                            slots_q <= clamp_slots(frm_slots);
                            dummy_q <= 1'b0;
                        end else begin
                            pls_q   <= 7'd0;
                            slots_q <= DUMMY_S;
                            dummy_q <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    hdr_cnt_q <= hdr_cnt_q + 1'b1;
                    if (state_d == S_DONE)
                        err_q <= 1'b1;
                end
                S_PAY: begin
                    if (last_sym) begin
                        sym_cnt_q <= '0;
                        // slot_cnt holds N-1 through DONE; DONE clears it.
                        if (!last_slot)
                            slot_q <= slot_q + 9'd1;
                    end else begin
                        sym_cnt_q <= sym_cnt_q + 7'd1;
                    end
                end
`ifdef PILOT_INSERT_EN
                S_PILOT: begin
                    sym_cnt_q <= (sym_cnt_q == PILOT_LAST) ? 7'd0 : sym_cnt_q + 7'd1;
                end
`endif
                S_DONE: begin
                    dummy_q <= 1'b0;
                    slot_q  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_frame_scheduler.sv
`timescale 1ns/1ps
module tb_pl_frame_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       frm_valid = 1'b0;
  logic       frm_ready;
  logic [6:0] frm_pls = '0;
  logic [8:0] frm_slots = '0;
  logic       hdr_en;
  logic [6:0] hdr_pls;
  logic       hdr_ready = 1'b0;
  logic [1:0] sym_sel;
  logic       pay_rd;
  logic [8:0] slot_cnt;
  logic       frame_start;
  logic       frame_done;
  logic       dummy_active;
  logic       hdr_err;
  logic [2:0] state_dbg;

  pl_frame_scheduler dut (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_pls(frm_pls), .frm_slots(frm_slots),
    .hdr_en(hdr_en), .hdr_pls(hdr_pls), .hdr_ready(hdr_ready),
    .sym_sel(sym_sel), .pay_rd(pay_rd), .slot_cnt(slot_cnt),
    .frame_start(frame_start), .frame_done(frame_done),
    .dummy_active(dummy_active), .hdr_err(hdr_err), .state_dbg(state_dbg)
  );

`ifdef PILOT_INSERT_EN
  localparam bit PIL = 1'b1;
`else
  localparam bit PIL = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- header generator model ----------------
  // mode 0: ready after gen_delay enabled cycles; 1: never ready; 2: always ready
  int gen_mode  = 0;
  int gen_delay = 3;
  int gen_cnt   = 0;
  always @(negedge clk) begin
    if (hdr_en) gen_cnt = gen_cnt + 1;
    else        gen_cnt = 0;
    case (gen_mode)
      1:       hdr_ready = 1'b0;
      2:       hdr_ready = 1'b1;
      default: hdr_ready = hdr_en && (gen_cnt >= gen_delay);
    endcase
  end

  // ---------------- frame monitor ----------------
  int m_hdr, m_reads, m_pil, m_pre, m_last, m_bad, m_rdy, m_starts;
  int m_start_at, m_done_seen, m_err, m_dum_done, m_prev_rd, m_dum;

  // Called just after an accept edge; follows the frame until frame_done.
  task automatic watch_frame(input logic [6:0] exp_pls, input int budget);
    int prev;
    m_hdr = 0; m_reads = 0; m_pil = 0; m_pre = -1; m_last = 0; m_bad = 0;
    m_rdy = 0; m_starts = 0; m_start_at = -1; m_done_seen = 0; m_err = 0;
    m_dum_done = 0; m_prev_rd = 0; m_dum = 0;
    prev = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (frame_start) begin
        m_starts++;
        if (m_start_at < 0) m_start_at = c;
      end
      if (hdr_en) begin
        m_hdr++;
        if (hdr_pls !== exp_pls || sym_sel !== 2'b01) m_bad++;
      end
      if (pay_rd) begin
        m_reads++;
        if (sym_sel !== 2'b10) m_bad++;
        if (int'(slot_cnt) > m_last) m_last = int'(slot_cnt);
      end
      if (sym_sel == 2'b11) begin
        if (m_pil == 0) m_pre = m_reads;
        m_pil++;
        if (pay_rd) m_bad++;
      end
      if (frm_ready) m_rdy++;
      if (dummy_active) m_dum++;
      if (frame_done) begin
        m_done_seen = 1;
        m_err       = int'(hdr_err);
        m_dum_done  = int'(dummy_active);
        m_prev_rd   = prev;
        if (sym_sel !== 2'b00 || pay_rd) m_bad++;
        break;
      end
      prev = int'(pay_rd);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0] pls;
    logic [8:0] slots;
    int         mode;
    int         delay;
    int         reads;
    int         pil;
    logic [6:0] hpls;
    int         hcyc;
    int         last;
    int         err;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    int rd;
    int cnt;

    vecs[0] = '{7'h04, 9'd2,   0, 122, 180,   0,              7'h04,                   122, 1,   0};
    vecs[1] = '{7'h45, 9'd17,  0, 10,  1530,  (PIL ? 36 : 0), (PIL ? 7'h45 : 7'h05),   10,  16,  0};
    vecs[2] = '{7'h12, 9'd0,   0, 5,   90,    0,              7'h12,                   5,   0,   0};
    vecs[3] = '{7'h33, 9'd1,   2, 0,   90,    0,              7'h33,                   3,   0,   0};
    vecs[4] = '{7'h41, 9'd16,  0, 4,   1440,  0,              (PIL ? 7'h41 : 7'h01),   4,   15,  0};
    vecs[5] = '{7'h7f, 9'd33,  0, 6,   2970,  (PIL ? 72 : 0), (PIL ? 7'h7f : 7'h3f),   6,   32,  0};
    vecs[6] = '{7'h02, 9'd400, 0, 3,   32400, 0,              7'h02,                   3,   359, 0};
    vecs[7] = '{7'h09, 9'd3,   1, 0,   0,     0,              7'h09,                   255, 0,   1};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({frm_ready, hdr_en, hdr_pls, sym_sel, pay_rd, slot_cnt,
                                 frame_start, frame_done, dummy_active, hdr_err}), 0);
    check("reset_state", int'(state_dbg), 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven frames ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      gen_mode  = vecs[i].mode;
      gen_delay = vecs[i].delay;
      frm_pls   = vecs[i].pls;
      frm_slots = vecs[i].slots;
      frm_valid = 1'b1;
      tx_en     = 1'b1;
      #1;
      check($sformatf("v%0d_ready_idle", i), int'(frm_ready), 1);
      @(posedge clk);
      #1;
      // Later changes to the descriptor inputs must not matter.
      frm_valid = 1'b0;
      tx_en     = 1'b0;
      frm_pls   = ~vecs[i].pls;
      frm_slots = 9'h1AB;
      watch_frame(vecs[i].hpls, vecs[i].reads + vecs[i].pil + 400);
      check($sformatf("v%0d_done_seen", i), m_done_seen, 1);
      check($sformatf("v%0d_start_count", i), m_starts, 1);
      check($sformatf("v%0d_start_cycle", i), m_start_at, 0);
      check($sformatf("v%0d_hdr_cycles", i), m_hdr, vecs[i].hcyc);
      check($sformatf("v%0d_reads", i), m_reads, vecs[i].reads);
      check($sformatf("v%0d_pilot_cycles", i), m_pil, vecs[i].pil);
      if (vecs[i].pil > 0)
        check($sformatf("v%0d_reads_before_pilot", i), m_pre, 1440);
      check($sformatf("v%0d_last_slot", i), m_last, vecs[i].last);
      check($sformatf("v%0d_phase_errors", i), m_bad, 0);
      check($sformatf("v%0d_ready_busy", i), m_rdy, 0);
      check($sformatf("v%0d_hdr_err", i), m_err, vecs[i].err);
      check($sformatf("v%0d_done_after_read", i), m_prev_rd, (vecs[i].reads > 0) ? 1 : 0);
      @(negedge clk);
      check($sformatf("v%0d_gap_sel", i), int'(sym_sel), 0);
      check($sformatf("v%0d_gap_slot", i), int'(slot_cnt), 0);
    end

    // ---- tx_en low keeps the block idle even with a valid descriptor ----
    frm_valid = 1'b1;
    frm_pls   = 7'h11;
    frm_slots = 9'd1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (frm_ready || hdr_en || state_dbg != 3'd0) cnt++;
    end
    check("idle_tx_off", cnt, 0);
    frm_valid = 1'b0;

    // ---- reset mid-payload at read #50 of slot 0 ----
    @(negedge clk);
    gen_mode  = 0;
    gen_delay = 4;
    frm_pls   = 7'h07;
    frm_slots = 9'd3;
    frm_valid = 1'b1;
    tx_en     = 1'b1;
    @(posedge clk);
    #1;
    frm_valid = 1'b0;
    tx_en     = 1'b0;
    rd = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (pay_rd) rd++;
      if (rd == 50) break;
    end
    check("rst_reached_read50", rd, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outputs", int'({frm_ready, hdr_en, hdr_pls, sym_sel, pay_rd, slot_cnt,
                                   frame_start, frame_done, dummy_active, hdr_err}), 0);
    check("rst_mid_state", int'(state_dbg), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_done || pay_rd) cnt++;
    end
    check("rst_no_done", cnt, 0);

    // ---- dummy frame, descriptor presented mid-dummy ----
    @(negedge clk);
    gen_mode  = 0;
    gen_delay = 7;
    frm_valid = 1'b0;
    tx_en     = 1'b1;
    @(posedge clk);
    #1;
    frm_pls   = 7'h06;
    frm_slots = 9'd1;
    frm_valid = 1'b1;
    watch_frame(7'h00, 3240 + 400);
    check("dummy_done_seen", m_done_seen, 1);
    check("dummy_hdr_cycles", m_hdr, 7);
    check("dummy_reads", m_reads, 3240);
    check("dummy_pilots", m_pil, 0);
    check("dummy_last_slot", m_last, 35);
    check("dummy_active_cycles", m_dum, 3248);
    check("dummy_active_done", m_dum_done, 1);
    check("dummy_ready_busy", m_rdy, 0);
    check("dummy_phase_errors", m_bad, 0);
    check("dummy_hdr_err", m_err, 0);
    @(negedge clk);
    check("post_dummy_idle_ready", int'(frm_ready), 1);
    check("post_dummy_flag", int'(dummy_active), 0);
    check("post_dummy_gap_sel", int'(sym_sel), 0);
    @(posedge clk);
    #1;
    frm_valid = 1'b0;
    tx_en     = 1'b0;
    watch_frame(7'h06, 500);
    check("queued_done_seen", m_done_seen, 1);
    check("queued_start_cycle", m_start_at, 0);
    check("queued_reads", m_reads, 90);
    check("queued_dummy_cycles", m_dum, 0);
    check("queued_phase_errors", m_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
